// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester and its address decoder.
//   NUM_REGS         : number of decoded registers (width of the one-hot select bus)
//   REG_A..REG_H     : register index constants 0..7
//   ADDR_W / DATA_W  : command address and data widths
//   apb_state_e      : requester FSM states (IDLE/SETUP/ACCESS/RESP)
package apb_pkg;

    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned DATA_W   = 8;

    localparam logic [ADDR_W-1:0] REG_A = 8'd0;
    localparam logic [ADDR_W-1:0] REG_B = 8'd1;
    localparam logic [ADDR_W-1:0] REG_C = 8'd2;
    localparam logic [ADDR_W-1:0] REG_D = 8'd3;
    localparam logic [ADDR_W-1:0] REG_E = 8'd4;
    localparam logic [ADDR_W-1:0] REG_F = 8'd5;
    localparam logic [ADDR_W-1:0] REG_G = 8'd6;
    localparam logic [ADDR_W-1:0] REG_H = 8'd7;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2,
        StResp   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/addr_onehot_decoder.sv
// Combinational register-index decoder.
//   i_addr    : register index
//   o_onehot  : one-hot select, bit i set when i_addr == i (all zero when out of range)
//   o_addr_ok : i_addr is a legal index (< NUM_REGS)
module addr_onehot_decoder
    import apb_pkg::*;
#(
    parameter int unsigned NUM_REGS = apb_pkg::NUM_REGS
) (
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [NUM_REGS-1:0] o_onehot,
    output logic                o_addr_ok
);

    always_comb begin
        o_onehot = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            o_onehot[i] = (32'(i_addr) == i);
        end
    end

    assign o_addr_ok = (32'(i_addr) < NUM_REGS);

endmodule

// File: rtl/apb_master_decoder.sv
// APB requester for the register block: accepts one read/write command at a time,
// decodes the index into a one-hot select, runs SETUP/ACCESS with wait states and a
// timeout, and returns a one-cycle response.
//   pclk, preset_n                : clock, asynchronous active-low reset
//   i_cmd_*/o_cmd_ready           : command valid/ready port
//   o_rsp_*                       : response strobe, read data, error, timeout cause
//   o_psel/o_penable/o_pwrite/o_pwdata/o_select_reg : APB request side
//   i_prdata/i_pready/i_pslverr   : APB completion side
module apb_master_decoder
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned NUM_REGS       = apb_pkg::NUM_REGS
) (
    input  logic                pclk,
    input  logic                preset_n,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic                i_cmd_write,
    input  logic [ADDR_W-1:0]   i_cmd_addr,
    input  logic [DATA_W-1:0]   i_cmd_wdata,
    output logic                o_rsp_valid,
    output logic [DATA_W-1:0]   o_rsp_rdata,
    output logic                o_rsp_err,
    output logic                o_rsp_timeout,
    output logic                o_psel,
    output logic                o_penable,
    output logic                o_pwrite,
    output logic [NUM_REGS-1:0] o_select_reg,
    output logic [DATA_W-1:0]   o_pwdata,
    input  logic [DATA_W-1:0]   i_prdata,
    input  logic                i_pready,
    input  logic                i_pslverr
);

    apb_state_e          r_state, w_state_next;
    logic [5:0]          r_wait, w_wait_next;
    logic                r_cmd_ready, w_cmd_ready_next;
    logic                r_psel, w_psel_next;
    logic                r_penable, w_penable_next;
    logic                r_pwrite, w_pwrite_next;
    logic [NUM_REGS-1:0] r_select, w_select_next;
    logic [DATA_W-1:0]   r_pwdata, w_pwdata_next;
    logic                r_rsp_valid, w_rsp_valid_next;
    logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata_next;
    logic                r_rsp_err, w_rsp_err_next;
    logic                r_rsp_timeout, w_rsp_timeout_next;

    logic [NUM_REGS-1:0] w_onehot;
    logic                w_addr_ok;

    addr_onehot_decoder #(
        .NUM_REGS (NUM_REGS)
    ) u_addr_dec (
        .i_addr    (i_cmd_addr),
        .o_onehot  (w_onehot),
        .o_addr_ok (w_addr_ok)
    );

    // Every output is a register, so next-state logic computes the values the
    // outputs take in the coming state. The output registers double as the
    // command latch: select/pwrite/pwdata are loaded at accept and held.
    always_comb begin
        w_state_next       = r_state;
        w_wait_next        = r_wait;
        w_psel_next        = 1'b0;
        w_penable_next     = 1'b0;
        w_pwrite_next      = 1'b0;
        w_select_next      = '0;
        w_pwdata_next      = '0;
        w_rsp_valid_next   = 1'b0;
        w_rsp_rdata_next   = '0;
        w_rsp_err_next     = 1'b0;
        w_rsp_timeout_next = 1'b0;

        unique case (r_state)
            StIdle: begin
                // r_cmd_ready is low for the first cycle after reset release
                if (i_cmd_valid && r_cmd_ready) begin
                    if (w_addr_ok) begin
                        w_state_next  = StSetup;
                        w_psel_next   = 1'b1;
                        w_pwrite_next = i_cmd_write;
                        w_select_next = w_onehot;
                        w_pwdata_next = i_cmd_write ? i_cmd_wdata : '0;
                    end else begin
                        // Bad index: answer with an error, never touch the bus
                        w_state_next     = StResp;
                        w_rsp_valid_next = 1'b1;
                        w_rsp_err_next   = 1'b1;
                    end
                end
            end
            StSetup: begin
                // pready is not looked at here
                w_state_next   = StAccess;
                w_wait_next    = '0;
                w_psel_next    = 1'b1;
                w_penable_next = 1'b1;
                w_pwrite_next  = r_pwrite;
                w_select_next  = r_select;
                w_pwdata_next  = r_pwdata;
            end
            StAccess: begin
                // pready is checked first so it wins over a coincident timeout
                if (i_pready) begin
                    w_state_next     = StResp;
                    w_rsp_valid_next = 1'b1;
                    w_rsp_err_next   = i_pslverr;
                    w_rsp_rdata_next = (r_pwrite || i_pslverr) ? '0 : i_prdata;
                end else if (r_wait + 6'd1 == 6'(TIMEOUT_CYCLES)) begin
                    w_state_next       = StResp;
                    w_rsp_valid_next   = 1'b1;
                    w_rsp_err_next     = 1'b1;
                    w_rsp_timeout_next = 1'b1;
                end else begin
                    w_wait_next    = r_wait + 6'd1;
                    w_psel_next    = 1'b1;
                    w_penable_next = 1'b1;
                    w_pwrite_next  = r_pwrite;
                    w_select_next  = r_select;
                    w_pwdata_next  = r_pwdata;
                end
            end
            StResp: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase

        w_cmd_ready_next = (w_state_next == StIdle);
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state       <= StIdle;
            r_wait        <= '0;
            r_cmd_ready   <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_select      <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_wait        <= w_wait_next;
            r_cmd_ready   <= w_cmd_ready_next;
            r_psel        <= w_psel_next;
            r_penable     <= w_penable_next;
            r_pwrite      <= w_pwrite_next;
            r_select      <= w_select_next;
            r_pwdata      <= w_pwdata_next;
            r_rsp_valid   <= w_rsp_valid_next;
            r_rsp_rdata   <= w_rsp_rdata_next;
            r_rsp_err     <= w_rsp_err_next;
            r_rsp_timeout <= w_rsp_timeout_next;
        end
    end

    assign o_cmd_ready   = r_cmd_ready;
    assign o_psel        = r_psel;
    assign o_penable     = r_penable;
    assign o_pwrite      = r_pwrite;
    assign o_select_reg  = r_select;
    assign o_pwdata      = r_pwdata;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_rsp_err     = r_rsp_err;
    assign o_rsp_timeout = r_rsp_timeout;

endmodule
